alu_div_sequencer: RTL
======================

// Module: alu_div_sequencer
// PURPOSE
//  Multi-cycle unsigned 32-bit divide controller that drives the datapath ALU.
//  Issues one ALU divide-step per clock through the ALU's DI/DO shift chain,
//  and applies the restore/take decision from ALU FLAGS.
//  Sits between the issue stage and the ALU. Returns quotient and remainder with a START/BUSY/DONE handshake.
// PARAMETERS
//  DIV_OP   4'h6  ALU INST code for the divide step
//  IDLE_OP  4'hF  ALU INST code driven when not in RUN
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET        in   1   synchronous, active-high reset
//  START        in   1   request; sampled only in IDLE
//  DIVIDEND     in   32  captured on accepted START
//  DIVISOR      in   32  captured on accepted START
//  BUSY         out  1   high in RUN
//  DONE         out  1   one-cycle pulse; results valid
//  QUOTIENT     out  32  Q register; held until next accepted START
//  REMAINDER    out  32  R register; held until next accepted START
//  DIV0         out  1   set when DIVISOR==0 at START; cleared on next START
//  ALU_A        out  32  divisor register D
//  ALU_B        out  32  partial remainder R
//  ALU_DI       out  32  Q register (dividend shifting out, quotient shifting in)
//  ALU_INST     out  4   DIV_OP in RUN, else IDLE_OP
//  ALU_CI       out  1   constant 0
//  ALU_FIRSTCYC out  1   constant 1 (ALU generates its own carry-in)
//  ALU_Z        in   32  ALU result, combinational from ALU_*
//  ALU_DO       in   32  ALU shift-chain output
//  ALU_FLAGS    in   4   [1]=carry (no borrow); others ignored
// BEHAVIOUR
//  ALU contract for INST=DIV_OP:
//   - Z = {B[30:0],DI[31]} - A mod 2^32
//   - FLAGS[1] = 1 iff no borrow
//   - DO = {DI[30:0],FLAGS[1]}
//   - Step completes in the same cycle; the ALU is combinational.
//  FSM states: IDLE, RUN, FIN. Counter cnt is 5 bits.
//  IDLE:
//   - START=1 and DIVISOR!=0: Q<=DIVIDEND, R<=0, D<=DIVISOR, cnt<=0, DIV0<=0, go RUN.
//   - START=1 and DIVISOR==0: Q<=32'hFFFFFFFF, R<=DIVIDEND, DIV0<=1, go FIN.
//  RUN, each edge:
//   - take = ALU_FLAGS[1] | R[31]. R[31] covers the 33rd bit lost by the shift.
//   - R <= take ? ALU_Z : {R[30:0],Q[31]}
//   - Q <= {ALU_DO[31:1],take}. Bit 0 is overridden by take.
//   - cnt<=cnt+1. At cnt==31 (32nd step) go FIN.
//  FIN:
//   - DONE=1 for exactly this cycle, then IDLE.
//   - START is not accepted in FIN.
//  Latency: 33 cycles from the START edge to the DONE cycle; divide-by-zero takes 1 cycle.
//   - Back-to-back: START is accepted in the first IDLE cycle after FIN.
//  START in RUN or FIN is ignored (not queued).
//  DIVISOR/DIVIDEND changes after START are ignored; operands are held in D, Q, R.
//  RESET, including mid-RUN, takes effect on the next edge:
//   - state IDLE; Q, R, D = 0; cnt = 0; DIV0, DONE, BUSY = 0.
//   - ALU_INST=IDLE_OP; other ALU_* outputs = 0, except ALU_FIRSTCYC=1.
//  All outputs are registered or decoded from state and registers. No combinational path from ALU_* in to any out.
//  Result: DIVIDEND = QUOTIENT*DIVISOR + REMAINDER, with REMAINDER < DIVISOR.
// TESTING
//  100/7 -> DONE 33 cycles after START; Q=14, R=2, DIV0=0; BUSY high for 32 cycles.
//  0xFFFFFFFF/0x80000000 -> Q=1, R=0x7FFFFFFF (exercises R[31] take path).
//  5/7 -> Q=0, R=5; 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0.
//  DIVISOR=0, DIVIDEND=0x1234 -> DONE next cycle; Q=0xFFFFFFFF, R=0x1234, DIV0=1.
//  START pulsed at RUN step 5 with new operands -> ignored; original result still returned.
//  RESET at step 10 -> next cycle BUSY=0, Q=R=0, ALU_INST=IDLE_OP; a new START runs a full 33 cycles.

Source files
------------

// File: rtl/alu_div_sequencer.sv
// rtl/alu_div_sequencer.sv - sequencer for 32-bit unsigned restoring divide, one ALU divide-step per clock
module alu_div_sequencer #(
  parameter logic [3:0] DIV_OP  = 4'h6,
  parameter logic [3:0] IDLE_OP = 4'hF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div0_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [31:0] alu_di_o,
  output logic [3:0]  alu_inst_o,
  output logic        alu_ci_o,
  output logic        alu_firstcyc_o,
  input  logic [31:0] alu_z_i,
  input  logic [31:0] alu_do_i,
  input  logic [3:0]  alu_flags_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic [31:0] dv_q, dv_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div0_q, div0_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  inst_q, inst_d;
  logic        take;

  // R[31] set means the shifted partial remainder is 33 bits wide and always exceeds D.
  assign take = alu_flags_i[1] | r_q[31];

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    div0_d  = div0_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (divisor_i != 32'd0) begin
            q_d     = dividend_i;
            r_d     = 32'd0;
            dv_d    = divisor_i;
            cnt_d   = 5'd0;
            div0_d  = 1'b0;
            state_d = S_RUN;
          end else begin
            q_d     = 32'hFFFF_FFFF;
            r_d     = dividend_i;
            div0_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_RUN: begin
        r_d   = take ? alu_z_i : {r_q[30:0], q_q[31]};
        q_d   = {alu_do_i[31:1], take};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
    inst_d = (state_d == S_RUN) ? DIV_OP : IDLE_OP;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      q_q     <= 32'd0;
      r_q     <= 32'd0;
      dv_q    <= 32'd0;
      cnt_q   <= 5'd0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inst_q  <= IDLE_OP;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign quotient_o     = q_q;
  assign remainder_o    = r_q;
  assign div0_o         = div0_q;
  assign alu_a_o        = dv_q;
  assign alu_b_o        = r_q;
  assign alu_di_o       = q_q;
  assign alu_inst_o     = inst_q;
  assign alu_ci_o       = 1'b0;
  assign alu_firstcyc_o = 1'b1;

  // Only the carry flag and DO[31:1] matter; the rest of the ALU return path is don't-care.
  logic unused_alu_bits;
  assign unused_alu_bits = ^{alu_flags_i[3:2], alu_flags_i[0], alu_do_i[0]};

endmodule
